// File: rtl/ifetch_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction fetch buffer.
//   fetch_state_e    : RUN (normal fetching) / DRAIN (discarding stale responses)
//   fetch_slot_t     : one ring entry {filled, pc, instr}
//   IFETCH_DEPTH_DEF : default ring depth
//   IFETCH_XLEN      : address / instruction width carried by fetch_slot_t
// -----------------------------------------------------------------------------
package ifetch_pkg;

   localparam int IFETCH_DEPTH_DEF = 2;
   localparam int IFETCH_XLEN      = 32;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic                   filled;
      logic [IFETCH_XLEN-1:0] pc;
      logic [IFETCH_XLEN-1:0] instr;
   } fetch_slot_t;

endpackage

// File: rtl/ifetch_ring.sv
// -----------------------------------------------------------------------------
// ifetch_ring
// Slot array for the fetch buffer. Three pointers walk the ring in order:
//   wr_ptr   : next slot to allocate (push, on request acceptance)
//   fill_ptr : next slot to receive a memory response (fill)
//   rd_ptr   : head slot presented to decode (pop)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   clear_i                drop every entry and rewind all pointers
//   push_i, push_pc_i      allocate a slot tagged with its PC
//   fill_i, fill_instr_i   write the returned instruction into the fill slot
//   pop_i                  release the head slot
//   head_*_o               head slot contents
//   wr/rd/fill_ptr_o       raw pointers for the credit and drain logic
// -----------------------------------------------------------------------------
module ifetch_ring
   import ifetch_pkg::*;
#(
   parameter  int DEPTH = IFETCH_DEPTH_DEF,
   localparam int PW    = $clog2(DEPTH) + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic [IFETCH_XLEN-1:0] push_pc_i,
   input  logic                   fill_i,
   input  logic [IFETCH_XLEN-1:0] fill_instr_i,
   input  logic                   pop_i,
   output logic                   head_filled_o,
   output logic [IFETCH_XLEN-1:0] head_pc_o,
   output logic [IFETCH_XLEN-1:0] head_instr_o,
   output logic [PW-1:0]          wr_ptr_o,
   output logic [PW-1:0]          rd_ptr_o,
   output logic [PW-1:0]          fill_ptr_o
);

   fetch_slot_t     r_slots [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_fill_ptr;

   logic [PW-2:0]   w_wr_idx;
   logic [PW-2:0]   w_rd_idx;
   logic [PW-2:0]   w_fill_idx;

   assign w_wr_idx   = r_wr_ptr[PW-2:0];
   assign w_rd_idx   = r_rd_ptr[PW-2:0];
   assign w_fill_idx = r_fill_ptr[PW-2:0];

   // Push, fill and pop never address the same slot in one cycle: push needs
   // a free slot, fill targets an allocated unfilled slot, pop a filled one.
   // NOTE: sequential state is written with <= so every read in this block sees
   // the pre-edge value, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill_ptr <= '0;
         // NOTE: the slot array is reset because decode sees the head contents
         // directly and must read zeros out of reset; it is only DEPTH entries.
         for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
      end else if (clear_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_slots[i].filled <= 1'b0;
      end else begin
         if (push_i) begin
            r_slots[w_wr_idx].pc     <= push_pc_i;
            r_slots[w_wr_idx].filled <= 1'b0;
            r_wr_ptr                 <= r_wr_ptr + PW'(1);
         end
         if (fill_i) begin
            r_slots[w_fill_idx].instr  <= fill_instr_i;
            r_slots[w_fill_idx].filled <= 1'b1;
            r_fill_ptr                 <= r_fill_ptr + PW'(1);
         end
         if (pop_i) begin
            r_slots[w_rd_idx].filled <= 1'b0;
            r_rd_ptr                 <= r_rd_ptr + PW'(1);
         end
      end
   end

   assign head_filled_o = r_slots[w_rd_idx].filled;
   assign head_pc_o     = r_slots[w_rd_idx].pc;
   assign head_instr_o  = r_slots[w_rd_idx].instr;
   assign wr_ptr_o      = r_wr_ptr;
   assign rd_ptr_o      = r_rd_ptr;
   assign fill_ptr_o    = r_fill_ptr;

endmodule

// File: rtl/ifetch_buffer.sv
// -----------------------------------------------------------------------------
// ifetch_buffer
// Fetch stage: issues in-order req/gnt requests for the current PC, tags each
// with its PC, buffers returned words and hands {instr, pc} to decode.
// A redirect (flush_i) empties the ring; responses still in flight are then
// counted down and discarded in DRAIN before fetching resumes.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   pc_i, pc_valid_i, pc_ready_o     fetch address handshake with the PC reg
//   flush_i                          redirect this cycle
//   imem_req_o, imem_addr_o,
//   imem_gnt_i                       request channel (word aligned address)
//   imem_rvalid_i, imem_rdata_i      in-order response channel
//   instr_valid_o, instr_ready_i,
//   instr_o, instr_pc_o              decode handshake and head entry
// XLEN must equal IFETCH_XLEN, the width of the ring slot type.
// -----------------------------------------------------------------------------
module ifetch_buffer
   import ifetch_pkg::*;
#(
   parameter int DEPTH = IFETCH_DEPTH_DEF,
   parameter int XLEN  = IFETCH_XLEN
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [XLEN-1:0] pc_i,
   input  logic            pc_valid_i,
   output logic            pc_ready_o,
   input  logic            flush_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o
);

   localparam int PW = $clog2(DEPTH) + 1;

   fetch_state_e  r_state;
   fetch_state_e  w_state_next;
   logic [PW-1:0] r_drop_cnt;
   logic [PW-1:0] w_drop_cnt_next;

   logic [PW-1:0] w_wr_ptr;
   logic [PW-1:0] w_rd_ptr;
   logic [PW-1:0] w_fill_ptr;
   logic [PW-1:0] w_used;
   logic [PW-1:0] w_outstanding;
   logic          w_credit_ok;
   logic          w_accept;
   logic          w_fill;
   logic          w_pop;
   logic          w_head_filled;
   logic          w_rvalid_counted;

   // used counts allocated slots (pending or filled); a slot popped this cycle
   // becomes available next cycle because only registered pointers are used.
   assign w_used        = w_wr_ptr - w_rd_ptr;
   assign w_outstanding = w_wr_ptr - w_fill_ptr;
   assign w_credit_ok   = w_used < PW'(DEPTH);

   // rst_ni gates the request so nothing is offered to memory while reset is
   // held, even with pc_valid_i already high.
   assign imem_req_o  = rst_ni & pc_valid_i & w_credit_ok & (r_state == RUN) & ~flush_i;
   assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
   assign w_accept    = imem_req_o & imem_gnt_i;
   assign pc_ready_o  = w_accept;

   // A response with nothing outstanding is a protocol error and is dropped.
   assign w_fill = imem_rvalid_i & (r_state == RUN) & ~flush_i & (w_outstanding != '0);

   assign instr_valid_o = w_head_filled;
   assign w_pop         = w_head_filled & instr_ready_i & ~flush_i;

   // A response arriving in the flush cycle itself is already consumed.
   assign w_rvalid_counted = imem_rvalid_i & (w_outstanding != '0);

   ifetch_ring #(
      .DEPTH (DEPTH)
   ) u_ring (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (flush_i),
      .push_i        (w_accept),
      .push_pc_i     (pc_i),
      .fill_i        (w_fill),
      .fill_instr_i  (imem_rdata_i),
      .pop_i         (w_pop),
      .head_filled_o (w_head_filled),
      .head_pc_o     (instr_pc_o),
      .head_instr_o  (instr_o),
      .wr_ptr_o      (w_wr_ptr),
      .rd_ptr_o      (w_rd_ptr),
      .fill_ptr_o    (w_fill_ptr)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= RUN;
         r_drop_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_drop_cnt <= w_drop_cnt_next;
      end
   end

   // NOTE: both next-state values get a default first so no path through the
   // case leaves them unassigned, which would otherwise infer latches.
   always_comb begin
      w_state_next    = r_state;
      w_drop_cnt_next = r_drop_cnt;
      case (r_state)
         RUN: begin
            if (flush_i) begin
               w_drop_cnt_next = w_outstanding - PW'(w_rvalid_counted);
               if (w_drop_cnt_next != '0) w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Further flushes change nothing here: the ring is already empty.
            if (imem_rvalid_i && (r_drop_cnt != '0)) begin
               w_drop_cnt_next = r_drop_cnt - PW'(1);
               if (r_drop_cnt == PW'(1)) w_state_next = RUN;
            end
         end
         default: w_state_next = RUN;
      endcase
   end

endmodule
